// File: rtl/vb_wb_pkg.sv
// Shared definitions for the VerilogBoy Wishbone control block:
// register word indices, CTRL/STATUS bit positions, ID constant and
// a byte-lane merge helper.
package vb_wb_pkg;

  // Word index within the 256-byte window (byte address bits [7:2])
  typedef enum logic [5:0] {
    REG_CTRL      = 6'h00,
    REG_STATUS    = 6'h01,
    REG_ROM_ADDR  = 6'h02,
    REG_ROM_DATA  = 6'h03,
    REG_FRAME_CNT = 6'h04,
    REG_ID        = 6'h05
  } reg_idx_e;

  localparam int CTRL_CORE_RUN = 0;
  localparam int CTRL_AUTO_INC = 1;
  localparam int CTRL_IRQ_EN   = 2;

  localparam int STAT_EMPTY      = 0;
  localparam int STAT_FULL       = 1;
  localparam int STAT_OVF        = 2;
  localparam int STAT_FRAME_PEND = 3;

  localparam logic [2:0]  CTRL_RESET = 3'b010;
  localparam logic [31:0] VB_ID      = 32'h5642_0001;

  // Replace only the bytes of old_val whose lane is selected
  function automatic logic [31:0] sel_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = sel[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vb_wb_if.sv
// Wishbone-classic slave bus from the Caravel management SoC.
interface vb_wb_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/vb_wb_fifo.sv
// Small synchronous FIFO holding {rom word address, rom word data} entries
// waiting to be written into the core's boot ROM. DEPTH must be a power of 2.
module vb_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_level   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still takes a push when the head leaves on the same edge
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointer and occupancy tracking; reset discards every stored entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, needs no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/vb_wb_ctrl.sv
// Wishbone-classic control/status slave for the VerilogBoy core.
// Holds the core in reset until software sets CORE_RUN and the boot-ROM
// download FIFO has drained, counts frames and optionally raises IRQs.
// Optional feature macro: VB_WB_IRQ_EN (enables CTRL.IRQ_EN and irq_o).
module vb_wb_ctrl
  import vb_wb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          ROM_AW     = 6
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  vb_wb_if.slave            wbs,
  output logic              core_rst_n_o,
  output logic              rom_wvalid_o,
  input  logic              rom_wready_i,
  output logic [ROM_AW-1:0] rom_waddr_o,
  output logic [31:0]       rom_wdata_o,
  input  logic              vblank_i,
  output logic [2:0]        irq_o
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = ROM_AW + 32;

`ifdef VB_WB_IRQ_EN
  localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
  localparam logic [2:0] CTRL_WMASK = 3'b011;
`endif

  logic              r_ack;
  logic [31:0]       r_dat;
  logic [2:0]        r_ctrl;
  logic [ROM_AW-1:0] r_rom_addr;
  logic              r_ovf;
  logic              r_pend;
  logic [15:0]       r_frame_cnt;
  logic              r_core_rst_n;

  logic              w_hit;
  logic              w_wr;
  logic [5:0]        w_idx;
  logic              w_wr_ctrl;
  logic              w_wr_status;
  logic              w_wr_rom_addr;
  logic              w_push_req;
  logic              w_push_ok;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [LW-1:0]     w_level;
  logic [7:0]        w_level8;
  logic [FW-1:0]     w_fifo_rdata;
  logic [31:0]       w_rdata;
  logic [31:0]       w_rom_addr_merged;
  logic              w_unused;

  assign w_hit = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                 (wbs.wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  assign w_idx = wbs.wbs_adr_i[7:2];

  // Register side effects happen only on the edge that ends the ack cycle
  assign w_wr          = r_ack & w_hit & wbs.wbs_we_i;
  assign w_wr_ctrl     = w_wr & (w_idx == REG_CTRL);
  assign w_wr_status   = w_wr & (w_idx == REG_STATUS);
  assign w_wr_rom_addr = w_wr & (w_idx == REG_ROM_ADDR);
  assign w_push_req    = w_wr & (w_idx == REG_ROM_DATA) & (wbs.wbs_sel_i == 4'hF);
  assign w_pop         = ~w_empty & rom_wready_i;
  assign w_push_ok     = w_push_req & (~w_full | w_pop);

  assign w_level8          = 8'(w_level);
  assign w_rom_addr_merged = sel_merge(32'(r_rom_addr), wbs.wbs_dat_i, wbs.wbs_sel_i);
  assign w_unused          = ^{wbs.wbs_adr_i[1:0], w_rom_addr_merged[31:ROM_AW]};

  vb_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .i_push  (w_push_ok),
    .i_pop   (w_pop),
    .i_wdata ({r_rom_addr, wbs.wbs_dat_i}),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Head of the FIFO is presented until accepted; outputs read 0 while empty
  assign rom_wvalid_o = ~w_empty;
  assign rom_waddr_o  = w_empty ? '0 : w_fifo_rdata[FW-1:32];
  assign rom_wdata_o  = w_empty ? '0 : w_fifo_rdata[31:0];

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign core_rst_n_o  = r_core_rst_n;

  // Read mux; unmapped and write-only offsets return zero
  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_CTRL:      w_rdata = {29'b0, r_ctrl};
      REG_STATUS: begin
        w_rdata[15:8]            = w_level8;
        w_rdata[STAT_FRAME_PEND] = r_pend;
        w_rdata[STAT_OVF]        = r_ovf;
        w_rdata[STAT_FULL]       = w_full;
        w_rdata[STAT_EMPTY]      = w_empty;
      end
      REG_ROM_ADDR:  w_rdata = 32'(r_rom_addr);
      REG_FRAME_CNT: w_rdata = {16'b0, r_frame_cnt};
      REG_ID:        w_rdata = VB_ID;
      default:       w_rdata = '0;
    endcase
  end

  // One wait state: ack the cycle after a hit, never on back-to-back cycles
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_hit & ~r_ack;
      r_dat <= (w_hit & ~r_ack) ? w_rdata : '0;
    end
  end

  // Control, pointer, sticky status and frame counter registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ctrl      <= CTRL_RESET;
      r_rom_addr  <= '0;
      r_ovf       <= 1'b0;
      r_pend      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_wr_ctrl && wbs.wbs_sel_i[0]) begin
        r_ctrl <= wbs.wbs_dat_i[2:0] & CTRL_WMASK;
      end

      if (w_wr_rom_addr) begin
        r_rom_addr <= w_rom_addr_merged[ROM_AW-1:0];
      end else if (w_push_ok && r_ctrl[CTRL_AUTO_INC]) begin
        r_rom_addr <= r_rom_addr + ROM_AW'(1);
      end

      if (w_push_req && !w_push_ok) begin
        r_ovf <= 1'b1;
      end else if (w_wr_status && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[STAT_OVF]) begin
        r_ovf <= 1'b0;
      end

      if (vblank_i) begin
        r_pend      <= 1'b1;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else if (w_wr_status && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[STAT_FRAME_PEND]) begin
        r_pend <= 1'b0;
      end
    end
  end

  // Core leaves reset only when software allows it and the download is done
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_core_rst_n <= 1'b0;
    end else begin
      r_core_rst_n <= r_ctrl[CTRL_CORE_RUN] & w_empty;
    end
  end

`ifdef VB_WB_IRQ_EN
  logic [2:0] r_irq;

  // Registered interrupt lines: frame pending (gated) and overflow
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_irq <= '0;
    end else begin
      r_irq <= {1'b0, r_ovf, r_pend & r_ctrl[CTRL_IRQ_EN]};
    end
  end

  assign irq_o = r_irq;
`else
  assign irq_o = 3'b000;
`endif

endmodule

// File: tb/tb_vb_wb_ctrl.sv
// Self-checking bench for vb_wb_ctrl: a transaction-level model (queue of
// pending ROM words plus register variables) predicts every output each
// cycle, and directed scenarios add hand-computed literal expectations.
module tb_vb_wb_ctrl;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 4;

  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_STATUS = BASE + 32'h04;
  localparam logic [31:0] A_RADDR  = BASE + 32'h08;
  localparam logic [31:0] A_RDATA  = BASE + 32'h0C;
  localparam logic [31:0] A_FRAME  = BASE + 32'h10;
  localparam logic [31:0] A_ID     = BASE + 32'h14;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } entry_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        coreRstN;
  logic        romWvalid;
  logic        romWready = 1'b0;
  logic [5:0]  romWaddr;
  logic [31:0] romWdata;
  logic        vblank = 1'b0;
  logic [2:0]  irq;

  int total = 0;
  int bad   = 0;

  vb_wb_if wbBus();

  vb_wb_ctrl #(
    .ADDR_BASE  (BASE),
    .FIFO_DEPTH (DEPTH),
    .ROM_AW     (6)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rstN),
    .wbs          (wbBus),
    .core_rst_n_o (coreRstN),
    .rom_wvalid_o (romWvalid),
    .rom_wready_i (romWready),
    .rom_waddr_o  (romWaddr),
    .rom_wdata_o  (romWdata),
    .vblank_i     (vblank),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  // Model state
  entry_t      mq[$];
  logic        mAck, mRun, mAutoInc, mIrqEn, mOvf, mPend, mCore;
  logic [31:0] mRdata;
  logic [5:0]  mRomAddr;
  logic [15:0] mFrame;
  logic [2:0]  mIrq;
  logic        mHit, mPop, mFullNow, mNextAck, mPushIt;
  logic [5:0]  mIdx;
  logic [31:0] mNextRd;
  entry_t      mPushEnt;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // What a register read returns, from the register map rules
  function automatic logic [31:0] modelRead(input logic [5:0] idx);
    logic [31:0] v;
    v = 32'h0;
    case (idx)
      6'h00: v = {29'h0, mIrqEn, mAutoInc, mRun};
      6'h01: v = {16'h0, 8'(mq.size()), 4'h0, mPend, mOvf,
                  (mq.size() == DEPTH), (mq.size() == 0)};
      6'h02: v = 32'(mRomAddr);
      6'h04: v = {16'h0, mFrame};
      6'h05: v = 32'h5642_0001;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  // Model update on every clock edge from the bench's own stimulus
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mq.delete();
      mAck = 0; mRdata = 0; mRun = 0; mAutoInc = 1; mIrqEn = 0;
      mRomAddr = 0; mOvf = 0; mPend = 0; mFrame = 0; mCore = 0; mIrq = 0;
    end else begin
      mHit     = wbBus.wbs_cyc_i && wbBus.wbs_stb_i &&
                 (wbBus.wbs_adr_i[31:8] == BASE[31:8]);
      mIdx     = wbBus.wbs_adr_i[7:2];
      mPop     = (mq.size() != 0) && romWready;
      mFullNow = (mq.size() == DEPTH);
      mNextAck = mHit && !mAck;
      mNextRd  = mNextAck ? modelRead(mIdx) : 32'h0;
      mCore    = mRun && (mq.size() == 0);
`ifdef VB_WB_IRQ_EN
      mIrq     = {1'b0, mOvf, mPend && mIrqEn};
`else
      mIrq     = 3'b000;
`endif
      mPushIt  = 0;
      if (mAck && mHit && wbBus.wbs_we_i) begin
        case (mIdx)
          6'h00: if (wbBus.wbs_sel_i[0]) begin
            mRun     = wbBus.wbs_dat_i[0];
            mAutoInc = wbBus.wbs_dat_i[1];
`ifdef VB_WB_IRQ_EN
            mIrqEn   = wbBus.wbs_dat_i[2];
`endif
          end
          6'h01: if (wbBus.wbs_sel_i[0]) begin
            if (wbBus.wbs_dat_i[2]) mOvf = 0;
            if (wbBus.wbs_dat_i[3]) mPend = 0;
          end
          6'h02: if (wbBus.wbs_sel_i[0]) mRomAddr = wbBus.wbs_dat_i[5:0];
          6'h03: if (wbBus.wbs_sel_i == 4'hF) begin
            if (!mFullNow || mPop) begin
              mPushIt    = 1;
              mPushEnt.a = mRomAddr;
              mPushEnt.d = wbBus.wbs_dat_i;
              if (mAutoInc) mRomAddr = mRomAddr + 6'd1;
            end else begin
              mOvf = 1;
            end
          end
          default: ;
        endcase
      end
      if (vblank) begin
        mFrame = mFrame + 16'd1;
        mPend  = 1;
      end
      if (mPop) void'(mq.pop_front());
      if (mPushIt) mq.push_back(mPushEnt);
      mAck   = mNextAck;
      mRdata = mNextRd;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (rstN) begin
      checkOutput("ack", 32'(wbBus.wbs_ack_o), 32'(mAck));
      if (mAck) checkOutput("rdata", wbBus.wbs_dat_o, mRdata);
      checkOutput("wvalid", 32'(romWvalid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        checkOutput("waddr", 32'(romWaddr), 32'(mq[0].a));
        checkOutput("wdata", romWdata, mq[0].d);
      end
      checkOutput("core_rst_n", 32'(coreRstN), 32'(mCore));
      checkOutput("irq", 32'(irq), 32'(mIrq));
    end
  end

  // One Wishbone classic access; optional vblank pulse on the ack cycle
  task automatic applyStimulus(input logic [31:0] adr, input logic we,
                               input logic [31:0] wdat, input logic [3:0] sel,
                               input bit vbOnAck,
                               output logic [31:0] rdat, output int waits);
    @(posedge clk); #1;
    wbBus.wbs_cyc_i = 1; wbBus.wbs_stb_i = 1; wbBus.wbs_we_i = we;
    wbBus.wbs_adr_i = adr; wbBus.wbs_dat_i = wdat; wbBus.wbs_sel_i = sel;
    waits = -1;
    rdat  = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wbBus.wbs_ack_o) begin
        waits = i;
        rdat  = wbBus.wbs_dat_o;
        break;
      end
    end
    if (waits < 0) checkOutput("ack_timeout", 32'h0, 32'h1);
    if (vbOnAck) vblank = 1;
    @(posedge clk); #1;
    wbBus.wbs_cyc_i = 0; wbBus.wbs_stb_i = 0; wbBus.wbs_we_i = 0;
    vblank = 0;
  endtask

  task automatic wbWrite(input logic [31:0] adr, input logic [31:0] d,
                         input logic [3:0] sel);
    logic [31:0] r;
    int w;
    applyStimulus(adr, 1'b1, d, sel, 1'b0, r, w);
  endtask

  task automatic wbRead(input logic [31:0] adr, output logic [31:0] d);
    int w;
    applyStimulus(adr, 1'b0, 32'h0, 4'hF, 1'b0, d, w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          waits;
    logic [5:0]  popped[$];

    wbBus.wbs_cyc_i = 0; wbBus.wbs_stb_i = 0; wbBus.wbs_we_i = 0;
    wbBus.wbs_sel_i = 0; wbBus.wbs_adr_i = 0; wbBus.wbs_dat_i = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_core_rst_n", 32'(coreRstN), 32'h0);
    checkOutput("reset_wvalid", 32'(romWvalid), 32'h0);
    checkOutput("reset_ack", 32'(wbBus.wbs_ack_o), 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    rstN = 1;
    idle(2);

    // ID / CTRL reads and the single wait state
    applyStimulus(A_ID, 1'b0, 32'h0, 4'hF, 1'b0, rd, waits);
    checkOutput("id_value", rd, 32'h5642_0001);
    checkOutput("id_wait_states", 32'(waits), 32'h1);
    wbRead(A_CTRL, rd);
    checkOutput("ctrl_reset", rd, 32'h0000_0002);
    checkOutput("core_held", 32'(coreRstN), 32'h0);

    // Out-of-window access is never acked
    @(posedge clk); #1;
    wbBus.wbs_cyc_i = 1; wbBus.wbs_stb_i = 1; wbBus.wbs_adr_i = BASE + 32'h100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("nonhit_ack", 32'(wbBus.wbs_ack_o), 32'h0);
    end
    @(posedge clk); #1;
    wbBus.wbs_cyc_i = 0; wbBus.wbs_stb_i = 0;

    // Three downloads with ROM held off, then drain in order
    wbWrite(A_RADDR, 32'h5, 4'h1);
    wbWrite(A_RDATA, 32'hA000_0000, 4'hF);
    wbWrite(A_RDATA, 32'hA000_0001, 4'hF);
    wbWrite(A_RDATA, 32'hA000_0002, 4'hF);
    wbWrite(A_RDATA, 32'hDEAD_BEEF, 4'h3);
    wbRead(A_STATUS, rd);
    checkOutput("status_level3", rd, 32'h0000_0300);
    wbRead(A_RADDR, rd);
    checkOutput("rom_addr_after3", rd, 32'h8);
    @(posedge clk); #1;
    romWready = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!romWvalid) break;
      popped.push_back(romWaddr);
    end
    checkOutput("drain_count", 32'(popped.size()), 32'h3);
    if (popped.size() == 3) begin
      checkOutput("drain_addr0", 32'(popped[0]), 32'h5);
      checkOutput("drain_addr1", 32'(popped[1]), 32'h6);
      checkOutput("drain_addr2", 32'(popped[2]), 32'h7);
    end
    @(posedge clk); #1;
    romWready = 0;

    // Overflow: five pushes into a four-entry FIFO
    wbWrite(A_RADDR, 32'h0, 4'h1);
    for (int i = 0; i < 5; i++) wbWrite(A_RDATA, 32'hB000_0000 + 32'(i), 4'hF);
    wbRead(A_RADDR, rd);
    checkOutput("rom_addr_ovf", rd, 32'h4);
    wbRead(A_STATUS, rd);
    checkOutput("status_ovf", rd, 32'h0000_0406);
    wbWrite(A_STATUS, 32'h4, 4'h1);
    wbRead(A_STATUS, rd);
    checkOutput("status_ovf_cleared", rd, 32'h0000_0402);

    // Core release waits for the download to finish
    wbWrite(A_CTRL, 32'h3, 4'h1);
    idle(3);
    checkOutput("core_held_nonempty", 32'(coreRstN), 32'h0);
    romWready = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!romWvalid) break;
    end
    checkOutput("core_at_last_pop", 32'(coreRstN), 32'h0);
    @(negedge clk);
    checkOutput("core_released", 32'(coreRstN), 32'h1);
    @(posedge clk); #1;
    romWready = 0;

    // Frame counting, set beating a coincident W1C
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; vblank = 1;
      @(posedge clk); #1; vblank = 0;
    end
    applyStimulus(A_STATUS, 1'b1, 32'h8, 4'h1, 1'b1, rd, waits);
    wbRead(A_FRAME, rd);
    checkOutput("frame_cnt", rd, 32'h3);
    wbRead(A_STATUS, rd);
    checkOutput("status_pend", rd, 32'h0000_0009);
    wbWrite(A_CTRL, 32'h7, 4'h1);
    idle(3);
    wbRead(A_CTRL, rd);
`ifdef VB_WB_IRQ_EN
    checkOutput("irq_frame", 32'(irq), 32'h1);
    checkOutput("ctrl_irq_en", rd, 32'h7);
`else
    checkOutput("irq_disabled", 32'(irq), 32'h0);
    checkOutput("ctrl_irq_en", rd, 32'h3);
`endif
    wbWrite(A_STATUS, 32'h8, 4'h1);
    idle(2);

    // Asynchronous reset in the middle of a drain and a bus ack
    wbWrite(A_RADDR, 32'h9, 4'h1);
    for (int i = 0; i < 3; i++) wbWrite(A_RDATA, 32'hC000_0000 + 32'(i), 4'hF);
    @(posedge clk); #1;
    wbBus.wbs_cyc_i = 1; wbBus.wbs_stb_i = 1; wbBus.wbs_we_i = 0;
    wbBus.wbs_adr_i = A_ID; wbBus.wbs_sel_i = 4'hF;
    romWready = 1;
    @(posedge clk); #1;
    checkOutput("pre_reset_ack", 32'(wbBus.wbs_ack_o), 32'h1);
    checkOutput("pre_reset_wvalid", 32'(romWvalid), 32'h1);
    rstN = 0;
    #1;
    checkOutput("async_ack_drop", 32'(wbBus.wbs_ack_o), 32'h0);
    checkOutput("async_wvalid_drop", 32'(romWvalid), 32'h0);
    checkOutput("async_core_rst", 32'(coreRstN), 32'h0);
    wbBus.wbs_cyc_i = 0; wbBus.wbs_stb_i = 0;
    romWready = 0;
    idle(2);
    rstN = 1;
    idle(1);
    wbRead(A_STATUS, rd);
    checkOutput("post_reset_empty", rd, 32'h0000_0001);
    wbRead(A_RADDR, rd);
    checkOutput("post_reset_rom_addr", rd, 32'h0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
